// File: rtl/fft_pkg.sv
// Shared constants, sample type and helpers for the FFT natural-order reorder block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_pkg;

    localparam int FFT_N     = 32;
    localparam int FFT_LOG2N = 5;
    localparam int FFT_DW    = 18;

    // One complex bin as stored in the reorder RAM: {re, im}.
    typedef struct packed {
        logic [FFT_DW-1:0] re;
        logic [FFT_DW-1:0] im;
    } cplx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

    // Bit-reverse an index; the FFT core emits bin bitrev(n) as its n-th sample.
    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx);
        logic [FFT_LOG2N-1:0] r;
        for (int b = 0; b < FFT_LOG2N; b++) begin
            r[b] = idx[FFT_LOG2N-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Two-bank register file holding the ping-pong frames of the reorder buffer.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; the caller owns bank/address sequencing.
//
// Ports: clk; we/wr_bank/wr_addr/wr_data synchronous write port;
//        rd_bank/rd_addr select the word driven on rd_data.
module fft_reorder_ram #(
    parameter int N     = 32,
    parameter int LOG2N = 5,
    parameter int W     = 36
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [LOG2N-1:0] wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_bank,
    input  logic [LOG2N-1:0] rd_addr,
    output logic [W-1:0]     rd_data
);

    // Bank select is the address MSB: words 0..N-1 are bank 0, N..2N-1 bank 1.
    logic [W-1:0] mem [2*N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_reorder.sv
// Captures bit-reversed FFT frames in a ping-pong buffer and replays them in natural bin order.
// Latency: N cycles first input to first output; index 0 appears 1 cycle after the last input.
// Backpressure: none; the reader keeps up with 1 sample/cycle, FFT_REORDER_OVF_EN drops writes into an unread bank.
//
// Ports: clk, rst (sync, active-high); valid_i/din_r/din_i from the FFT core;
//        valid_o/dout_r/dout_i/index_o natural-order stream, frame_done_o on index N-1,
//        overflow_o sticky drop flag (tied 0 unless FFT_REORDER_OVF_EN is defined).
module fft_reorder
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = FFT_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [DW-1:0]    din_r,
    input  logic [DW-1:0]    din_i,
    output logic             valid_o,
    output logic [DW-1:0]    dout_r,
    output logic [DW-1:0]    dout_i,
    output logic [LOG2N-1:0] index_o,
    output logic             frame_done_o,
    output logic             overflow_o
);

    logic [LOG2N-1:0] wc_q;
    logic [LOG2N-1:0] rc_q;
    logic [LOG2N-1:0] wr_addr;
    logic             wb_q;
    logic             rb_q;
    logic [1:0]       full_q;
    logic [1:0]       full_d;
    rd_state_t        state_q;
    rd_state_t        state_d;
    logic             wr_drop;
    logic             wr_en;
    logic             wr_last;
    logic             rd_fire;
    logic             rd_last;
    cplx_t            wr_cplx;
    cplx_t            rd_cplx;

`ifdef FFT_REORDER_OVF_EN
    // The target bank still holds an undrained frame: refuse the sample.
    assign wr_drop = valid_i & full_q[wb_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (wr_drop) begin
            overflow_o <= 1'b1;
        end
    end
`else
    assign wr_drop    = 1'b0;
    assign overflow_o = 1'b0;
`endif

    assign wr_en      = valid_i & ~wr_drop;
    // N is a power of two, so the all-ones count is the last sample of a frame.
    assign wr_last    = wr_en & (wc_q == '1);
    assign wr_addr    = bitrev(wc_q);
    assign wr_cplx.re = din_r;
    assign wr_cplx.im = din_i;

    fft_reorder_ram #(
        .N     (N),
        .LOG2N (LOG2N),
        .W     (2*DW)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_bank (wb_q),
        .wr_addr (wr_addr),
        .wr_data (wr_cplx),
        .rd_bank (rb_q),
        .rd_addr (rc_q),
        .rd_data (rd_cplx)
    );

    // Write side: counter wraps naturally at N, bank flips on the last sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q <= '0;
            wb_q <= 1'b0;
        end else if (wr_en) begin
            wc_q <= wc_q + 1'b1;
            if (wr_last) begin
                wb_q <= ~wb_q;
            end
        end
    end

    // Reader state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. IDLE issues index 0 on the same edge it leaves, which gives the
    // single cycle between the last write and the first output.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (full_q[rb_q]) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // full_d includes a frame completing on this edge, so back-to-back
                // frames stream without a bubble.
                if (rd_last && !full_d[~rb_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reader strobes and full-flag update. On a same-bank collision (only possible
    // without the overflow check) the fresh frame wins and stays marked full.
    always_comb begin
        rd_fire = (state_q == STREAM) | full_q[rb_q];
        rd_last = (state_q == STREAM) & (rc_q == '1);
        full_d  = full_q;
        if (rd_last) begin
            full_d[rb_q] = 1'b0;
        end
        if (wr_last) begin
            full_d[wb_q] = 1'b1;
        end
    end

    // rc stays 0 while IDLE, so the first read of a frame always addresses bin 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q   <= '0;
            rb_q   <= 1'b0;
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
            if (rd_fire) begin
                rc_q <= rc_q + 1'b1;
            end
            if (rd_last) begin
                rb_q <= ~rb_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
            dout_r       <= '0;
            dout_i       <= '0;
            index_o      <= '0;
        end else begin
            valid_o      <= rd_fire;
            frame_done_o <= rd_last;
            if (rd_fire) begin
                dout_r  <= rd_cplx.re;
                dout_i  <= rd_cplx.im;
                index_o <= rc_q;
            end
        end
    end

endmodule

// File: tb/tb_fft_reorder.sv
module tb_fft_reorder;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int DW    = 18;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic [DW-1:0]    din_r = '0;
    logic [DW-1:0]    din_i = '0;
    logic             valid_o;
    logic [DW-1:0]    dout_r;
    logic [DW-1:0]    dout_i;
    logic [LOG2N-1:0] index_o;
    logic             frame_done_o;
    logic             overflow_o;

    always #5 clk = ~clk;

    fft_reorder dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .din_r        (din_r),
        .din_i        (din_i),
        .valid_o      (valid_o),
        .dout_r       (dout_r),
        .dout_i       (dout_i),
        .index_o      (index_o),
        .frame_done_o (frame_done_o),
        .overflow_o   (overflow_o)
    );

    typedef struct {
        logic [DW-1:0]    re;
        logic [DW-1:0]    im;
        logic [LOG2N-1:0] idx;
        logic             done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   n_checks      = 0;
    int   n_fail        = 0;
    int   cyc           = 0;
    int   last_acc      = 0;
    int   first_out_cyc = -1;
    int   out_vld_cnt   = 0;
    int   done_cnt      = 0;
    int   cur_run       = 0;
    int   last_run      = 0;
    int   d0            = 0;
    int   v0            = 0;
    bit   mon_en        = 1'b1;
    bit   found         = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LOG2N-1:0] brev(input logic [LOG2N-1:0] x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Issue cnt samples n = 0..cnt-1 (din_r = tag | n, din_i = -n), bit-reversed
    // source order implied. Only a complete frame is expected at the output:
    // natural bin k came from sample bitrev(k).
    task automatic send(input logic [DW-1:0] tag, input bit gaps, input int cnt);
        logic [DW-1:0] nv;
        exp_t          e;
        if (cnt == N) begin
            for (int k = 0; k < N; k++) begin
                nv     = DW'(brev(LOG2N'(k)));
                e.re   = tag | nv;
                e.im   = -nv;
                e.idx  = LOG2N'(k);
                e.done = (k == N-1);
                sb.push_back(e);
            end
        end
        for (int n = 0; n < cnt; n++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    valid_i = 1'b0;
                end
            end
            @(negedge clk);
            nv       = DW'(n);
            valid_i  = 1'b1;
            din_r    = tag | nv;
            din_i    = -nv;
            last_acc = cyc + 1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        #1;
        check(name, 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    // Monitor: compares every presented output against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (valid_o === 1'b1) begin
                    out_vld_cnt++;
                    cur_run++;
                    if (index_o == '0) first_out_cyc = cyc;
                    if (frame_done_o === 1'b1) done_cnt++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: index=%0d dout_r=0x%0h with nothing expected", index_o, dout_r);
                    end else begin
                        mon_e = sb.pop_front();
                        check("dout_r",     32'(dout_r),       32'(mon_e.re));
                        check("dout_i",     32'(dout_i),       32'(mon_e.im));
                        check("index_o",    32'(index_o),      32'(mon_e.idx));
                        check("frame_done", 32'(frame_done_o), 32'(mon_e.done));
                    end
                end else begin
                    if (cur_run != 0) last_run = cur_run;
                    cur_run = 0;
                    check("done_without_valid", 32'(frame_done_o), 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid_o",      32'(valid_o),      32'd0);
        check("rst_dout_r",       32'(dout_r),       32'd0);
        check("rst_dout_i",       32'(dout_i),       32'd0);
        check("rst_index_o",      32'(index_o),      32'd0);
        check("rst_frame_done_o", 32'(frame_done_o), 32'd0);
        check("rst_overflow_o",   32'(overflow_o),   32'd0);
        rst = 1'b0;

        // Single gapless frame, first output 1 cycle after the last input
        send('0, 1'b0, N);
        idle();
        wait_drain("t1_drain");
        check("t1_latency", 32'(first_out_cyc), 32'(last_acc + 1));

        // Three back-to-back tagged frames
        d0 = done_cnt;
        v0 = out_vld_cnt;
        send(18'h00100, 1'b0, N);
        send(18'h00200, 1'b0, N);
        send(18'h00300, 1'b0, N);
        idle();
        wait_drain("t2_drain");
        check("t2_done_pulses", 32'(done_cnt - d0),    32'd3);
        check("t2_valid_count", 32'(out_vld_cnt - v0), 32'd96);
        check("t2_run_length",  32'(last_run),         32'd96);
        check("t2_overflow",    32'(overflow_o),       32'd0);

        // Frame with random input gaps
        send('0, 1'b1, N);
        idle();
        wait_drain("t3_drain");
        check("t3_latency", 32'(first_out_cyc), 32'(last_acc + 1));

        // Reset at the 16th output, then a clean frame
        send(18'h00040, 1'b0, N);
        idle();
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            #1;
            if (valid_o === 1'b1 && index_o == 5'd15) found = 1'b1;
        end
        check("t5_saw_index15", 32'(found), 32'd1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        #1;
        check("t5_valid_o",    32'(valid_o),      32'd0);
        check("t5_dout_r",     32'(dout_r),       32'd0);
        check("t5_dout_i",     32'(dout_i),       32'd0);
        check("t5_index_o",    32'(index_o),      32'd0);
        check("t5_frame_done", 32'(frame_done_o), 32'd0);
        rst = 1'b0;
        send(18'h00080, 1'b0, N);
        idle();
        wait_drain("t5_drain");
        check("t5_latency", 32'(first_out_cyc), 32'(last_acc + 1));

        // Reset after 10 samples discards the partial frame
        send(18'h02000, 1'b0, 10);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(18'h000C0, 1'b0, N);
        idle();
        wait_drain("t6_drain");
        check("t6_latency", 32'(first_out_cyc), 32'(last_acc + 1));

`ifdef FFT_REORDER_OVF_EN
        // Both banks preloaded full: the next write is dropped
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b0;
        force dut.full_q = 2'b11;
        @(negedge clk);
        valid_i = 1'b1;
        din_r   = 18'h2ABCD;
        din_i   = 18'h00000;
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        check("ovf_flag",       32'(overflow_o),                     32'd1);
        check("ovf_wc_held",    32'(dut.wc_q),                       32'd0);
        check("ovf_not_stored", 32'(dut.u_ram.mem[0][2*DW-1:DW] != 18'h2ABCD), 32'd1);
        release dut.full_q;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ovf_cleared", 32'(overflow_o), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
`else
        check("ovf_tied_low", 32'(overflow_o), 32'd0);
`endif

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_reorder.md
# fft_reorder

Natural-order reorder buffer placed directly downstream of the 32-point `FFT` core. The core emits each 32-bin frame in bit-reversed order, with `finish` as the per-sample strobe and 18-bit `X_r`/`X_i`. This block captures each frame in a ping-pong buffer and replays it in natural bin order (X[0]..X[31]) with an index tag. It supports back-to-back frames with no gaps.

## Interface
- `N`, 32: points per frame; power of two.
- `LOG2N`, 5: log2(N); index and counter width.
- `DW`, 18: width of each real and imaginary component.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  input sample strobe; connects to FFT `finish`.
- `din_r`  in  DW  real part, bit-reversed order; connects to FFT `X_r`.
- `din_i`  in  DW  imaginary part; connects to FFT `X_i`.
- `valid_o`  out  1  output sample valid.
- `dout_r`  out  DW  real part, natural order.
- `dout_i`  out  DW  imaginary part, natural order.
- `index_o`  out  LOG2N  bin index of the current output.
- `frame_done_o`  out  1  one-cycle pulse, coincident with `index_o == N-1`.
- `overflow_o`  out  1  sticky overflow flag.

## Operation
- Storage: two banks of N x 2*DW each. Write bank `wb` and read bank `rb` are each one-bit pointers. Each bank has a `full` flag.
- Write side:
  - Write counter `wc` (LOG2N bits) advances only on `valid_i`.
  - Sample is written to `bank[wb][bitrev(wc)]`.
  - On the write with `wc == N-1`: set `full[wb]`, toggle `wb`, wrap `wc` to 0.
  - Gaps in `valid_i` are allowed; a partial frame waits indefinitely.
- Read side, state machine with states IDLE and STREAM:
  - IDLE -> STREAM when `full[rb]` is set. Read counter `rc` starts at 0.
  - STREAM: each cycle, present `bank[rb][rc]` with `index_o = rc` and `valid_o = 1`, then `rc++`.
  - On `rc == N-1`: clear `full[rb]`, toggle `rb`, and pulse `frame_done_o`. If the new `rb` is full, including a bank that becomes full on this same edge, stay in STREAM with `rc = 0`; otherwise go to IDLE.
  - Outputs are registered. `valid_o = 0` in IDLE, and `dout_*` hold their last value.
- Overflow: a write whose target bank `full[wb]` is still set (the reader has not drained it) is dropped. `wc` does not advance and `overflow_o` is set until `rst`. Continuous input at one sample per cycle never overflows.
- Simultaneous events: a write completing a frame and a read finishing a frame on the same edge are both honoured. The reader may immediately consume the newly full bank.
- Reset: `wc`, `rc`, `wb`, `rb` and both `full` flags clear to 0, and the state goes to IDLE. Any partial or unread frames are discarded. Reset values: `valid_o = 0`, `dout_r = 0`, `dout_i = 0`, `index_o = 0`, `frame_done_o = 0`, `overflow_o = 0`.

## Timing
- First sample of a frame is accepted at edge E0 and the last at E0+N-1, with no gaps.
- Output index k is registered at edge E0+N+k. Latency is N cycles from first input to first output, and 1 cycle from last input to index 0.
- Back-to-back frames produce `valid_o` continuously high with `index_o` cycling 0..N-1.
- `frame_done_o` is registered together with index N-1.
- `overflow_o` is registered at the edge of the dropped write.

## Configuration
- `FFT_REORDER_OVF_EN` defined:
  - Full-bank check is active.
  - Offending writes are dropped.
  - `overflow_o` is sticky as described in Operation.
- `FFT_REORDER_OVF_EN` undefined:
  - No check is made; writes always proceed and may overwrite an unread bank.
  - `full` is still set on a frame write, so the reader still streams it.
  - `overflow_o` is tied to 0.

## Structure
- Package `fft_pkg` holds:
  - constants `FFT_N`, `FFT_LOG2N`, `FFT_DW`;
  - the `bitrev` function, reversing LOG2N bits;
  - a typedef for the complex sample, a packed {re, im} of 2*DW bits.
- Sub-module `fft_reorder_ram`: two-bank register file with one synchronous write port (bank, addr, data, we) and one read port (bank, addr). Control logic stays in `fft_reorder`.

## Test plan
- Single frame, sample n carries `din_r = n`, `din_i = -n`: output index k gives `dout_r = bitrev(k)`; index 1 -> 16, index 3 -> 24, index 31 -> 31. First `valid_o` follows the last input by exactly 1 cycle, and `frame_done_o` pulses at k = 31.
- Three back-to-back frames tagged 0x100, 0x200, 0x300 in `din_r` upper bits: 96 consecutive `valid_o` cycles, correct per-frame tags, 3 `frame_done_o` pulses, `overflow_o = 0`.
- Random gaps in `valid_i` (about 50% duty) over one frame: output content is identical to the gapless run, and output starts 1 cycle after the 32nd accepted sample.
- With `FFT_REORDER_OVF_EN` defined, force an overflow through a directed state preload (both banks full, reader in IDLE) and send one write: `overflow_o` rises 1 cycle later, the sample is not stored, and `wc` is unchanged.
- Assert `rst` for 1 cycle at the 16th output of a frame: the next cycle shows all outputs 0 and `valid_o = 0`; a fresh frame afterwards reorders correctly.
- Assert `rst` after 10 input samples: the partial frame is discarded, and the next 32 samples form a clean frame.
